// File: rtl/vga_bayer_dither_out.sv
// ---------------------------------------------------------------------------
// vga_bayer_dither_out
//
// Output stage between the VGA timing generator / colour path and the
// 2-bit-per-channel VGA pins. Reduces RGB (default RGB565) to RGB222 using
// 4x4 ordered (Bayer) dithering and delays hsync/vsync by the same two stages
// so that they stay aligned with the dithered pixels. Every output is a flop.
//
// Flow control: none. There is no valid/ready handshake and no stall; one
// pixel is accepted every clock and appears exactly 2 clocks later.
//
// Optional build macro:
//   VGA_BAYER_DITHER_TEMPORAL_EN - rotates the Bayer index once per frame
//   (frame edge = vsync_in entering VSYNC_ACTIVE). Undefined by default, in
//   which case the output is frame-invariant.
//
// Ports:
//   clock       pixel clock
//   reset       asynchronous, active-high; clears all flops and outputs
//   hsync_in    horizontal sync from timing generator
//   vsync_in    vertical sync from timing generator
//   display_on  visible-area flag, same cycle as hpos/vpos
//   hpos, vpos  pixel column / row (only bits [1:0] index the matrix)
//   red/green/blue   input colour, same cycle as hpos
//   vga_hsync, vga_vsync           syncs delayed by 2 clocks
//   vga_red, vga_green, vga_blue   dithered 2-bit colour, 0 outside display
// ---------------------------------------------------------------------------

// Per-channel split of c*3 into integer level q (0..3), 4-bit fraction f
// (left-justified, zero-filled for narrow channels) and a saturation flag.
module vga_bayer_dither_chan #(
    parameter int W = 5
) (
    input  logic [W-1:0] c,
    output logic [1:0]   q,
    output logic [3:0]   f,
    output logic         sat
);
    logic [W+1:0] lvl;
    logic [W+3:0] frac_ext;
    logic         unused_frac_low;

    // c*3 as c + 2c, kept at W+2 bits so it never overflows.
    assign lvl = {2'b00, c} + {1'b0, c, 1'b0};
    assign q   = lvl[W+1:W];

    // Appending four zeros lets one slice serve every width: for W>=4 it
    // picks the top 4 fraction bits, for W<4 it left-justifies them.
    assign frac_ext        = {lvl[W-1:0], 4'b0000};
    assign f               = frac_ext[W+3:W];
    assign unused_frac_low = ^frac_ext[W-1:0];

    assign sat = &c;
endmodule

module vga_bayer_dither_out #(
    parameter int   W_RED        = 5,
    parameter int   W_GREEN      = 6,
    parameter int   W_BLUE       = 5,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic [W_RED-1:0]   red,
    input  logic [W_GREEN-1:0] green,
    input  logic [W_BLUE-1:0]  blue,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [1:0]         vga_red,
    output logic [1:0]         vga_green,
    output logic [1:0]         vga_blue
);
    // Row-major 4x4 Bayer matrix, indexed by {yi, xi}.
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic [1:0] xi, yi;
    logic       unused_pos_high;

    assign unused_pos_high = ^{hpos[9:2], vpos[9:2]};

`ifdef VGA_BAYER_DITHER_TEMPORAL_EN
    logic [1:0] frame_cnt;
    logic       vsync_prev;
    logic       frame_edge;

    assign frame_edge = (vsync_prev != VSYNC_ACTIVE) && (vsync_in == VSYNC_ACTIVE);

    // Held in reset, so an edge that coincides with reset is never counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_prev <= 1'b0;
            frame_cnt  <= 2'd0;
        end else begin
            vsync_prev <= vsync_in;
            if (frame_edge) frame_cnt <= frame_cnt + 2'd1;
        end
    end

    // Row offset uses the bit-swapped count so the four frames visit four
    // distinct diagonal shifts of the matrix.
    assign xi = hpos[1:0] + frame_cnt;
    assign yi = vpos[1:0] + {frame_cnt[0], frame_cnt[1]};
`else
    assign xi = hpos[1:0];
    assign yi = vpos[1:0];
`endif

    // ---- combinational per-channel decomposition --------------------------
    logic [1:0] q_r, q_g, q_b;
    logic [3:0] f_r, f_g, f_b;
    logic       sat_r, sat_g, sat_b;

    vga_bayer_dither_chan #(.W(W_RED)) u_chan_r (
        .c(red), .q(q_r), .f(f_r), .sat(sat_r)
    );
    vga_bayer_dither_chan #(.W(W_GREEN)) u_chan_g (
        .c(green), .q(q_g), .f(f_g), .sat(sat_g)
    );
    vga_bayer_dither_chan #(.W(W_BLUE)) u_chan_b (
        .c(blue), .q(q_b), .f(f_b), .sat(sat_b)
    );

    // ---- stage 1 ----------------------------------------------------------
    logic       s1_hsync, s1_vsync, s1_de;
    logic [3:0] s1_t;
    logic [1:0] s1_q_r, s1_q_g, s1_q_b;
    logic [3:0] s1_f_r, s1_f_g, s1_f_b;
    logic       s1_sat_r, s1_sat_g, s1_sat_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_t     <= 4'd0;
            s1_q_r   <= 2'd0;
            s1_q_g   <= 2'd0;
            s1_q_b   <= 2'd0;
            s1_f_r   <= 4'd0;
            s1_f_g   <= 4'd0;
            s1_f_b   <= 4'd0;
            s1_sat_r <= 1'b0;
            s1_sat_g <= 1'b0;
            s1_sat_b <= 1'b0;
        end else begin
            s1_hsync <= hsync_in;
            s1_vsync <= vsync_in;
            s1_de    <= display_on;
            s1_t     <= BAYER[{yi, xi}];
            s1_q_r   <= q_r;
            s1_q_g   <= q_g;
            s1_q_b   <= q_b;
            s1_f_r   <= f_r;
            s1_f_g   <= f_g;
            s1_f_b   <= f_b;
            s1_sat_r <= sat_r;
            s1_sat_g <= sat_g;
            s1_sat_b <= sat_b;
        end
    end

    // ---- stage 2 ----------------------------------------------------------
    // q + (f > t) cannot exceed 3 for c below all-ones; the clamp is only a
    // guard so the 2-bit result can never wrap.
    function automatic logic [1:0] dither(input logic       de,
                                          input logic       sat,
                                          input logic [1:0] q,
                                          input logic [3:0] f,
                                          input logic [3:0] t);
        logic [2:0] sum;
        logic [1:0] res;
        sum = {1'b0, q} + {2'b00, (f > t)};
        res = 2'd0;
        if (!de)              res = 2'd0;
        else if (sat)         res = 2'd3;
        else if (sum > 3'd3)  res = 2'd3;
        else                  res = sum[1:0];
        return res;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_red   <= 2'd0;
            vga_green <= 2'd0;
            vga_blue  <= 2'd0;
        end else begin
            vga_hsync <= s1_hsync;
            vga_vsync <= s1_vsync;
            vga_red   <= dither(s1_de, s1_sat_r, s1_q_r, s1_f_r, s1_t);
            vga_green <= dither(s1_de, s1_sat_g, s1_q_g, s1_f_g, s1_t);
            vga_blue  <= dither(s1_de, s1_sat_b, s1_q_b, s1_f_b, s1_t);
        end
    end
endmodule

// File: tb/tb_vga_bayer_dither_out.sv
module tb_vga_bayer_dither_out;
    localparam int   WR = 5;
    localparam int   WG = 6;
    localparam int   WB = 5;
    localparam logic VA = 1'b0;

    // ---- clock / reset ----------------------------------------------------
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          hsync_in = 1'b1, vsync_in = 1'b1, display_on = 1'b0;
    logic [9:0]    hpos = '0, vpos = '0;
    logic [WR-1:0] red = '0;
    logic [WG-1:0] green = '0;
    logic [WB-1:0] blue = '0;
    logic          vga_hsync, vga_vsync;
    logic [1:0]    vga_red, vga_green, vga_blue;

    always #20 clock = ~clock;

    vga_bayer_dither_out #(
        .W_RED(WR), .W_GREEN(WG), .W_BLUE(WB), .VSYNC_ACTIVE(VA)
    ) dut (
        .clock(clock), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on),
        .hpos(hpos), .vpos(vpos),
        .red(red), .green(green), .blue(blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
    );

    // ---- reference model & scoreboard ------------------------------------
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];   // {hsync, vsync, red[1:0], green[1:0], blue[1:0]}
    int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int m_fc = 0;           // model frame counter
    logic m_prev_vs = 1'b0; // model of the previous sampled vsync

    // Level c*3/(2^w - ... ) in 4-bit fractional form, then ordered dither.
    function automatic int exp_chan(int c, int w, int t);
        int scale, lvl, q, frac, f, s;
        scale = 1 << w;
        if (c == scale - 1) return 3;
        lvl  = c * 3;
        q    = lvl / scale;
        frac = lvl % scale;
        f    = (frac * 16) / scale;
        s    = q + ((f > t) ? 1 : 0);
        return (s > 3) ? 3 : s;
    endfunction

    function automatic logic [7:0] exp_pix(logic hs, logic vs, logic de,
                                           int h, int v, int r, int g, int b);
        int xo, yo, t, er, eg, eb;
        xo = 0;
        yo = 0;
`ifdef VGA_BAYER_DITHER_TEMPORAL_EN
        xo = m_fc;
        yo = ((m_fc % 2) * 2) + (m_fc / 2);
`endif
        t  = bayer[(((v % 4) + yo) % 4) * 4 + (((h % 4) + xo) % 4)];
        er = de ? exp_chan(r, WR, t) : 0;
        eg = de ? exp_chan(g, WG, t) : 0;
        eb = de ? exp_chan(b, WB, t) : 0;
        return {hs, vs, er[1:0], eg[1:0], eb[1:0]};
    endfunction

    // Reset leaves two all-zero output cycles in front of the first pixel.
    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        m_fc = 0;
        m_prev_vs = 1'b0;
    endtask

    // ---- driver: one pixel per clock, returns the output 2 pixels earlier --
    // Entered and left at posedge+1; outputs are sampled on the negedge.
    task automatic step(input logic hs, input logic vs, input logic de,
                        input int h, input int v, input int r, input int g,
                        input int b, output logic [7:0] obs,
                        output logic [7:0] expv);
        hsync_in   = hs;
        vsync_in   = vs;
        display_on = de;
        hpos       = h[9:0];
        vpos       = v[9:0];
        red        = r[WR-1:0];
        green      = g[WG-1:0];
        blue       = b[WB-1:0];
        exp_q.push_back(exp_pix(hs, vs, de, h, v, r, g, b));
        if (vs == VA && m_prev_vs != VA) m_fc = (m_fc + 1) % 4;
        m_prev_vs = vs;
        @(negedge clock);
        obs  = {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue};
        expv = exp_q.pop_front();
        @(posedge clock);
        #1;
    endtask

    // ---- tests -----------------------------------------------------------
    task automatic test_reset();
        logic [7:0] o, e;
        display_on = 1'b1;
        red        = 5'd31;
        reset      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({vga_hsync, vga_vsync, vga_red, vga_green, vga_blue} !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold got=%h want=00",
                     {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue});
        end
        reset = 1'b0;
        reset_model();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, i, 0, 31, 0, 0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_release[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_red_tile();
        logic [7:0] o, e;
        int twos;
        twos = 0;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, o, e);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(1'b1, 1'b1, 1'b1, i % 4, i / 4, 16, 0, 0, o, e);
            else        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL red_tile[%0d] got=%h want=%h", i, o, e);
            end
            if (o[5:4] == 2'd2) twos++;
        end
        checks++;
        if (twos != 8) begin
            failures++;
            $display("FAIL red_tile_count got=%0d want=8", twos);
        end
    endtask

    task automatic test_green_tile();
        logic [7:0] o, e;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(1'b1, 1'b1, 1'b1, 4 + i % 4, 8 + i / 4, 0, 21, 0, o, e);
            else        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL green_tile[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] o, e;
        for (int i = 0; i < 18; i++) begin
            if (i < 8)       step(1'b1, 1'b1, 1'b1, i, 3, 31, 63, 0, o, e);
            else if (i < 16) step(1'b1, 1'b1, 1'b1, 1020 + i, 1023, 0, 0, 0, o, e);
            else             step(1'b1, 1'b1, 1'b1, i, 0, 0, 63, 31, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL extremes[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_sync();
        logic [7:0] o, e;
        for (int i = 0; i < 16; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                 i, 0, 31, 63, 31, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sync[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] o, e;
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 31)), o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_midline_reset();
        logic [7:0] o, e;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, i, 2, 16 + i, 40, 31, o, e);
        reset = 1'b1;
        #1;
        checks++;
        if ({vga_hsync, vga_vsync, vga_red, vga_green, vga_blue} !== 8'h00) begin
            failures++;
            $display("FAIL midline_async got=%h want=00",
                     {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        reset_model();
        for (int i = 8; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b1, i, 2, 16 + i, 40, 31, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midline_resume[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_temporal();
        logic [7:0] o, e;
        for (int fr = 0; fr < 6; fr++) begin
            for (int i = 0; i < 6; i++) begin
                step(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b1, 0, 0, 16, 0, 0, o, e);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL temporal[%0d.%0d] got=%h want=%h", fr, i, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_red_tile();
        test_green_tile();
        test_extremes();
        test_sync();
        test_random();
        test_midline_reset();
        test_temporal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
